// File: rtl/led_choreo_sequencer.sv
// Step sequencer feeding pattern/speed/pause to the LED pattern generator.
// An 8-entry table is replayed in auto mode; manual controls pass through otherwise.
module led_choreo_sequencer #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mode_auto,
  input  logic [2:0] manual_pat,
  input  logic       manual_speed,
  input  logic       pause_in,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] last_step,
  output logic [2:0] pat_sel,
  output logic       speed_sel,
  output logic       pause_out,
  output logic [2:0] step_idx,
  output logic       step_strobe,
  output logic       running
);

  localparam int            PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    tbl_q [8];
  logic [7:0]    tbl_d [8];
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    beat_q, beat_d;
  logic [3:0]    dur_q, dur_d;
  logic [2:0]    pat_q, pat_d;
  logic [2:0]    idx_q, idx_d;
  logic          spd_q, spd_d;
  logic          pause_q, pause_d;
  logic          strobe_q, strobe_d;
  logic          run_q, run_d;

  logic          tick, step_end;
  logic [2:0]    nxt_idx, load_idx;
  logic [7:0]    load_ent;

  // A zero duration field wraps to 15 here, giving the 16-beat step for free.
  assign tick     = (pre_q == PRE_MAX);
  assign step_end = tick && (beat_q == dur_q - 4'd1);
  assign nxt_idx  = (idx_q >= last_step) ? 3'd0 : idx_q + 3'd1;
  assign load_idx = (state_q == S_IDLE) ? 3'd0 : nxt_idx;
  // Write-first: a same-cycle write to the entry being loaded wins.
  assign load_ent = (wr_en && (wr_addr == load_idx)) ? wr_data : tbl_q[load_idx];

  always_comb begin
    state_d  = state_q;
    tbl_d    = tbl_q;
    pre_d    = pre_q;
    beat_d   = beat_q;
    dur_d    = dur_q;
    pat_d    = pat_q;
    idx_d    = idx_q;
    spd_d    = spd_q;
    pause_d  = pause_q;
    run_d    = run_q;
    strobe_d = 1'b0;
    if (ena) begin
      if (wr_en) tbl_d[wr_addr] = wr_data;
      case (state_q)
        S_IDLE: begin
          pat_d   = manual_pat;
          spd_d   = manual_speed;
          pause_d = pause_in;
          run_d   = 1'b0;
          if (mode_auto) begin
            state_d = S_RUN;
            idx_d   = 3'd0;
            pre_d   = '0;
            beat_d  = 4'd0;
            pat_d   = load_ent[2:0];
            spd_d   = load_ent[3];
            dur_d   = load_ent[7:4];
            pause_d = 1'b0;
            run_d   = 1'b1;
          end
        end
        default: begin
          if (!mode_auto) begin
            state_d = S_IDLE;
            pat_d   = manual_pat;
            spd_d   = manual_speed;
            pause_d = pause_in;
            run_d   = 1'b0;
          end else if (pause_in) begin
            state_d = S_HOLD;
            pause_d = 1'b1;
          end else begin
            // Leaving HOLD counts this cycle, so the freeze lasts exactly as long as pause_in.
            state_d = S_RUN;
            pause_d = 1'b0;
            pre_d   = tick ? '0 : pre_q + PW'(1);
            if (step_end) begin
              idx_d    = nxt_idx;
              beat_d   = 4'd0;
              pat_d    = load_ent[2:0];
              spd_d    = load_ent[3];
              dur_d    = load_ent[7:4];
              strobe_d = 1'b1;
            end else if (tick) begin
              beat_d = beat_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 8; i++) tbl_q[i] <= 8'h40 | 8'(i);
      pre_q    <= '0;
      beat_q   <= 4'd0;
      dur_q    <= 4'd4;
      pat_q    <= 3'd0;
      idx_q    <= 3'd0;
      spd_q    <= 1'b0;
      pause_q  <= 1'b0;
      strobe_q <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tbl_q    <= tbl_d;
      pre_q    <= pre_d;
      beat_q   <= beat_d;
      dur_q    <= dur_d;
      pat_q    <= pat_d;
      idx_q    <= idx_d;
      spd_q    <= spd_d;
      pause_q  <= pause_d;
      strobe_q <= strobe_d;
      run_q    <= run_d;
    end
  end

  assign pat_sel     = pat_q;
  assign speed_sel   = spd_q;
  assign pause_out   = pause_q;
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;
  assign running     = run_q;

endmodule

// File: tb/tb_led_choreo_sequencer.sv
// Directed bench for led_choreo_sequencer with TICK_DIV=4; step strobes go
// through an expected/actual scoreboard, levels are checked in place.
module tb_led_choreo_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       mode_auto;
  logic [2:0] manual_pat;
  logic       manual_speed;
  logic       pause_in;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] last_step;
  logic [2:0] pat_sel;
  logic       speed_sel;
  logic       pause_out;
  logic [2:0] step_idx;
  logic       step_strobe;
  logic       running;

  led_choreo_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode_auto(mode_auto),
    .manual_pat(manual_pat), .manual_speed(manual_speed), .pause_in(pause_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .last_step(last_step),
    .pat_sel(pat_sel), .speed_sel(speed_sel), .pause_out(pause_out),
    .step_idx(step_idx), .step_strobe(step_strobe), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] pat;
    logic [2:0] idx;
    logic       spd;
  } ev_t;

  ev_t exp_q[$];
  ev_t act_q[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the edge number that produced it.
  always @(posedge clk) begin
    #2;
    if (step_strobe === 1'b1)
      act_q.push_back('{cyc: cyc, pat: pat_sel, idx: step_idx, spd: speed_sel});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic [2:0] p, input logic [2:0] i, input logic s);
    exp_q.push_back('{cyc: c, pat: p, idx: i, spd: s});
  endtask

  task automatic sb_drain(input string tag);
    ev_t e, a;
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk({tag, "_cyc"}, a.cyc, e.cyc);
      chk({tag, "_pat"}, 32'(a.pat), 32'(e.pat));
      chk({tag, "_idx"}, 32'(a.idx), 32'(e.idx));
      chk({tag, "_spd"}, 32'(a.spd), 32'(e.spd));
    end
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int p, q;
    rst_n = 1'b0; ena = 1'b1; mode_auto = 1'b0; manual_pat = 3'd6; manual_speed = 1'b0;
    pause_in = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; last_step = 3'd1;

    // Reset values and manual passthrough
    #1;
    chk("rst_pat", 32'(pat_sel), 0);
    chk("rst_idx", 32'(step_idx), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_strobe", 32'(step_strobe), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("manual_pat", 32'(pat_sel), 6);

    // Program entries 0/1 and start the sequence
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h2D;
    @(negedge clk) begin wr_addr = 3'd1; wr_data = 8'h13; end
    @(negedge clk) begin wr_en = 1'b0; last_step = 3'd1; mode_auto = 1'b1; end
    p = cyc + 1;
    push_ev(p + 8, 3'd3, 3'd1, 1'b0);
    push_ev(p + 12, 3'd5, 3'd0, 1'b1);
    wait_to(p);
    chk("start_pat", 32'(pat_sel), 5);
    chk("start_spd", 32'(speed_sel), 1);
    chk("start_run", 32'(running), 1);
    chk("start_pause", 32'(pause_out), 0);
    wait_to(p + 12);
    sb_drain("seq");

    // Pause for 10 sampled cycles inside step 0
    wait_to(p + 14); pause_in = 1'b1;
    wait_to(p + 15);
    chk("hold_pause", 32'(pause_out), 1);
    wait_to(p + 20);
    chk("hold_pat", 32'(pat_sel), 5);
    wait_to(p + 24); pause_in = 1'b0;
    wait_to(p + 25);
    chk("resume_pause", 32'(pause_out), 0);
    push_ev(p + 30, 3'd3, 3'd1, 1'b0);
    push_ev(p + 34, 3'd5, 3'd0, 1'b1);
    wait_to(p + 34);
    sb_drain("pause");

    // Write-first on the advance into step 1, then shrink last_step
    wait_to(p + 41); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h17;
    wait_to(p + 42); wr_en = 1'b0;
    wait_to(p + 43); last_step = 3'd0;
    push_ev(p + 42, 3'd7, 3'd1, 1'b0);
    push_ev(p + 46, 3'd5, 3'd0, 1'b1);
    push_ev(p + 54, 3'd5, 3'd0, 1'b1);
    wait_to(p + 54);
    sb_drain("collide");

    // ena low for 20 cycles, with an ignored write
    wait_to(p + 56); ena = 1'b0;
    wait_to(p + 57); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h01;
    wait_to(p + 58); wr_en = 1'b0;
    wait_to(p + 60);
    chk("ena_pat", 32'(pat_sel), 5);
    chk("ena_idx", 32'(step_idx), 0);
    chk("ena_strobe", 32'(step_strobe), 0);
    wait_to(p + 76); ena = 1'b1;
    push_ev(p + 82, 3'd5, 3'd0, 1'b1);
    wait_to(p + 82);
    sb_drain("ena");

    // Abort from HOLD back to manual
    wait_to(p + 84); pause_in = 1'b1;
    wait_to(p + 86);
    chk("abort_hold_pause", 32'(pause_out), 1);
    chk("abort_hold_run", 32'(running), 1);
    manual_pat = 3'd3; manual_speed = 1'b1; mode_auto = 1'b0;
    wait_to(p + 87);
    chk("abort_pat", 32'(pat_sel), 3);
    chk("abort_spd", 32'(speed_sel), 1);
    chk("abort_run", 32'(running), 0);
    pause_in = 1'b0;
    sb_drain("abort");

    // Duration field 0 means 16 beats, single repeating step
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h02;
    @(negedge clk) begin wr_en = 1'b0; mode_auto = 1'b1; end
    q = cyc + 1;
    push_ev(q + 64, 3'd2, 3'd0, 1'b0);
    push_ev(q + 128, 3'd2, 3'd0, 1'b0);
    wait_to(q);
    chk("dur0_pat", 32'(pat_sel), 2);
    wait_to(q + 100);
    chk("dur0_mid_pat", 32'(pat_sel), 2);
    wait_to(q + 128);
    sb_drain("dur0");

    // Asynchronous reset mid-run restores outputs and the table
    rst_n = 1'b0;
    #1;
    chk("arst_pat", 32'(pat_sel), 0);
    chk("arst_run", 32'(running), 0);
    chk("arst_idx", 32'(step_idx), 0);
    mode_auto = 1'b0; manual_pat = 3'd6; manual_speed = 1'b0; last_step = 3'd7;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("arst_manual", 32'(pat_sel), 6);
    mode_auto = 1'b1;
    q = cyc + 1;
    push_ev(q + 16, 3'd1, 3'd1, 1'b0);
    wait_to(q);
    chk("reinit_pat", 32'(pat_sel), 0);
    chk("reinit_run", 32'(running), 1);
    wait_to(q + 16);
    sb_drain("reinit");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/led_choreo_sequencer.md
Name: led_choreo_sequencer

Overview:
- Programmable step sequencer that drives the pattern-select, speed-select and pause controls of the LED pattern generator.
- Holds an 8-entry choreography table. In auto mode it steps through entries 0..last_step, holding each for a programmed number of beats, then wraps to 0.
- In manual mode the manual controls pass through unchanged.
- Sits between the top-level ui_in/uio_in pins and led_pattern_generator.

Parameters:
- TICK_DIV, 50000, clock cycles per beat (>=2); prescaler width is $clog2(TICK_DIV).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; 0 freezes all state
- mode_auto  input  1  1 = run the table, 0 = manual passthrough
- manual_pat  input  3  pattern used in manual mode
- manual_speed  input  1  speed bit used in manual mode
- pause_in  input  1  level pause request
- wr_en  input  1  table write strobe
- wr_addr  input  3  table entry index
- wr_data  input  8  entry fields: [2:0] pattern, [3] speed, [7:4] duration in beats (0 means 16)
- last_step  input  3  index of the final step before wrap
- pat_sel  output  3  pattern to the generator
- speed_sel  output  1  speed to the generator
- pause_out  output  1  pause to the generator
- step_idx  output  3  current table index
- step_strobe  output  1  one-cycle pulse on every step advance
- running  output  1  high in RUN or HOLD

Behaviour:
- Reset (async, rst_n=0):
  - Table entry i resets to 8'h40|i (pattern i, speed 0, 4 beats).
  - Outputs reset to: pat_sel=0, speed_sel=0, pause_out=0, step_idx=0, step_strobe=0, running=0.
  - State resets to IDLE; prescaler and beat_cnt reset to 0.
- ena=0: no state, counter, table or output register changes; writes are ignored; step_strobe=0.
- All outputs are registered. Every input effect appears on the cycle after it is sampled.
- States:
  - IDLE:
    - pat_sel<=manual_pat, speed_sel<=manual_speed, pause_out<=pause_in, running=0.
    - mode_auto=1 -> RUN. On entry: step_idx=0, prescaler=0, beat_cnt=0, and entry 0 is loaded into pat_sel/speed_sel/cur_dur.
  - RUN:
    - Prescaler counts 0..TICK_DIV-1. A tick occurs on the cycle it equals TICK_DIV-1.
    - On a tick, if beat_cnt==cur_dur-1 (cur_dur=16 when the field is 0), advance:
      - step_idx <= (step_idx>=last_step) ? 0 : step_idx+1.
      - Load that entry; beat_cnt=0; step_strobe=1 for one cycle.
    - Otherwise, on a tick, beat_cnt++.
    - Each step therefore lasts exactly dur*TICK_DIV cycles.
    - pause_in=1 -> HOLD.
  - HOLD:
    - Prescaler and beat_cnt are frozen; pause_out=1; pat_sel/speed_sel are held.
    - pause_in=0 -> RUN, resuming from the frozen counts; pause_out=0 next cycle.
  - From RUN or HOLD, mode_auto=0 -> IDLE (takes priority over all other events); manual values apply next cycle.
- pause_out equals the state flag in auto mode: 1 in HOLD, 0 in RUN.
- Table writes:
  - Accepted in any state.
  - Outputs are copied from the table only when a step is entered. Writing the active entry does not change the current outputs or cur_dur.
  - A write to the entry being loaded in the same cycle is write-first: the new data is loaded.
- last_step changed below step_idx: the next advance wraps to 0; the current step completes normally.
- last_step=0: step 0 repeats, with step_strobe pulsing on each repeat.
- Reset mid-operation: immediate return to reset values, and the table is re-initialised.

Test Plan:
- Reset values: assert rst_n=0 mid-RUN -> all outputs 0 immediately; after release with mode_auto=0 and manual_pat=6, pat_sel=6 one cycle later.
- Sequence and wrap:
  - Setup: TICK_DIV=4; write entry0=8'h2D (pat 5, spd 1, 2 beats) and entry1=8'h13 (pat 3, 1 beat); last_step=1; raise mode_auto at cycle T.
  - Expected: at T+1, pat_sel=5, speed=1, running=1.
  - Expected: at T+9, pat_sel=3, step_idx=1, strobe pulse.
  - Expected: at T+13, pat_sel=5, step_idx=0, strobe pulse.
- Pause: in the same sequence, assert pause_in for 10 cycles inside step 0 -> pause_out=1 one cycle later; step 0 total duration becomes 8+10 cycles; no strobe while paused.
- Duration 0: entry0=8'h02, last_step=0 -> strobe every 64 cycles, pat_sel stays 2.
- Write collision and shrink:
  - Rewriting entry1 on the exact advance cycle into step1 -> the new pattern is output.
  - Lowering last_step to 0 while in step 1 -> the next advance goes to step 0.
- ena and abort: ena=0 for 20 cycles mid-step -> no output change, and the step end is delayed by 20 cycles; mode_auto=0 while in HOLD -> IDLE with manual values next cycle.
